// File: rtl/led_matrix_scan_driver.sv
// 8x8 bicolour LED matrix row scanner: requests each row bitmap, then drives row/column pins with dwell and blanking.
// Optional macro SCAN_BRIGHTNESS_EN adds a 3-bit brightness input that trims the lit part of each dwell.
module led_matrix_scan_driver #(
  parameter int WIDTH        = 8,
  parameter int BIT_OF_WIDTH = 3,
  parameter int DWELL_CYCLES = 1024,
  parameter int DWELL_BITS   = 10,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
`ifdef SCAN_BRIGHTNESS_EN
  input  logic [2:0]              brightness,
`endif
  input  logic [2*WIDTH-1:0]      row_data,
  output logic [BIT_OF_WIDTH-1:0] count,
  output logic [WIDTH-1:0]        row_sel,
  output logic [WIDTH-1:0]        col_red,
  output logic [WIDTH-1:0]        col_green,
  output logic                    frame_start
);

  typedef enum logic [1:0] {IDLE, REQ, DISPLAY, BLANK} state_t;

  localparam logic [DWELL_BITS-1:0]   REQ_LAST   = DWELL_BITS'(1);
  localparam logic [DWELL_BITS-1:0]   DWELL_LAST = DWELL_BITS'(DWELL_CYCLES - 1);
  localparam logic [DWELL_BITS-1:0]   BLANK_LAST = DWELL_BITS'(BLANK_CYCLES - 1);
  localparam logic [BIT_OF_WIDTH-1:0] ROW_LAST   = BIT_OF_WIDTH'(WIDTH - 1);
  localparam logic [WIDTH-1:0]        ALL_OFF    = '1;

  state_t                  state_q, state_d;
  logic [DWELL_BITS-1:0]   timer_q, timer_d;
  logic [BIT_OF_WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0]        row_sel_q, row_sel_d;
  logic [WIDTH-1:0]        col_red_q, col_red_d;
  logic [WIDTH-1:0]        col_green_q, col_green_d;
  logic                    col_lit;

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q + 1'b1;
    count_d     = count_q;
    row_sel_d   = row_sel_q;
    col_red_d   = col_red_q;
    col_green_d = col_green_q;
    // Dropping enable blanks the pins at once but keeps the row so a re-enable resumes it.
    if (state_q != IDLE && !enable) begin
      state_d     = IDLE;
      timer_d     = '0;
      row_sel_d   = ALL_OFF;
      col_red_d   = '0;
      col_green_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          timer_d     = '0;
          row_sel_d   = ALL_OFF;
          col_red_d   = '0;
          col_green_d = '0;
          if (enable) state_d = REQ;
        end
        REQ: begin
          if (timer_q == REQ_LAST) begin
            state_d     = DISPLAY;
            timer_d     = '0;
            col_red_d   = row_data[WIDTH-1:0];
            col_green_d = row_data[2*WIDTH-1:WIDTH];
            row_sel_d   = ~(WIDTH'(1) << count_q);
          end
        end
        DISPLAY: begin
          if (timer_q == DWELL_LAST) begin
            state_d     = BLANK;
            timer_d     = '0;
            row_sel_d   = ALL_OFF;
            col_red_d   = '0;
            col_green_d = '0;
          end
        end
        BLANK: begin
          if (timer_q == BLANK_LAST) begin
            state_d = REQ;
            timer_d = '0;
            count_d = (count_q == ROW_LAST) ? '0 : count_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      timer_q     <= '0;
      count_q     <= '0;
      row_sel_q   <= ALL_OFF;
      col_red_q   <= '0;
      col_green_q <= '0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      count_q     <= count_d;
      row_sel_q   <= row_sel_d;
      col_red_q   <= col_red_d;
      col_green_q <= col_green_d;
    end
  end

`ifdef SCAN_BRIGHTNESS_EN
  // Product (brightness+1)*DWELL_CYCLES reaches 8*DWELL_CYCLES, so keep one bit of headroom
  // for DWELL_CYCLES == 2**DWELL_BITS at full brightness.
  localparam int BW = DWELL_BITS + 4;
  logic [BW-1:0] lit_limit;
  always_comb begin
    lit_limit = ((BW'(brightness) + BW'(1)) * BW'(DWELL_CYCLES)) >> 3;
    col_lit   = (state_q != DISPLAY) || ({4'b0, timer_q} < lit_limit);
  end
`else
  assign col_lit = 1'b1;
`endif

  assign count       = count_q;
  assign row_sel     = row_sel_q;
  assign col_red     = col_lit ? col_red_q : '0;
  assign col_green   = col_lit ? col_green_q : '0;
  assign frame_start = (state_q == REQ) && (timer_q == '0) && (count_q == '0);

endmodule

// File: tb/tb_led_matrix_scan_driver.sv
// Self-checking bench for led_matrix_scan_driver against a row-period arithmetic model.
// Build with SCAN_BRIGHTNESS_EN defined to also exercise the brightness trim.
module tb_led_matrix_scan_driver;

`ifdef SCAN_BRIGHTNESS_EN
  localparam int D = 8;
`else
  localparam int D = 4;
`endif
  localparam int B = 2;
  localparam int P = 2 + D + B;
  localparam int F = 8 * P;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic [2:0]  br_q = 3'd7;
  logic [15:0] row_data;
  logic [2:0]  count;
  logic [7:0]  row_sel, col_red, col_green;
  logic        frame_start;

  logic        use_gen = 1'b1;
  logic [15:0] rnd_q = 16'h0;
  logic [15:0] gen_q = 16'h0;

  int n_chk = 0;
  int n_err = 0;
  int cyc_n = 0;

  // Model state: scan activity, cycles since activation, row at activation, held row, latched bitmap.
  bit          m_on = 1'b0;
  int          m_t = 0;
  int          m_c0 = 0;
  int          m_cnt = 0;
  logic [15:0] m_lat = 16'h0;

  always #5 clk = ~clk;

  // Frame generator: registered bitmap for the requested row.
  always @(posedge clk) gen_q <= {8'h00, 8'h81 | (8'h01 << count)};
  assign row_data = use_gen ? gen_q : rnd_q;

  led_matrix_scan_driver #(
    .WIDTH(8), .BIT_OF_WIDTH(3), .DWELL_CYCLES(D), .DWELL_BITS(4), .BLANK_CYCLES(B)
  ) dut (
    .clk(clk),
    .rst(rst),
    .enable(enable),
`ifdef SCAN_BRIGHTNESS_EN
    .brightness(br_q),
`endif
    .row_data(row_data),
    .count(count),
    .row_sel(row_sel),
    .col_red(col_red),
    .col_green(col_green),
    .frame_start(frame_start)
  );

  function automatic int m_phase();
    return m_t % P;
  endfunction

  function automatic int m_row();
    return m_on ? (m_c0 + m_t / P) % 8 : m_cnt;
  endfunction

  function automatic logic [27:0] expect_out();
    logic [2:0] c;
    logic [7:0] rs, cr, cg;
    logic       fs;
    int         p;
    c = 3'(m_row()); rs = 8'hFF; cr = 8'h00; cg = 8'h00; fs = 1'b0;
    if (m_on) begin
      p  = m_phase();
      fs = (p == 0) && (c == 3'd0);
      if (p >= 2 && p < 2 + D) begin
        rs = ~(8'h01 << c);
        if (p - 2 < ((int'(br_q) + 1) * D) / 8) begin
          cr = m_lat[7:0];
          cg = m_lat[15:8];
        end
      end
    end
    return {c, rs, cr, cg, fs};
  endfunction

  function automatic logic [27:0] actual_out();
    return {count, row_sel, col_red, col_green, frame_start};
  endfunction

  // Drive inputs for the coming edge, step the model across it, then settle past the edge.
  task automatic tick(input logic en, input logic r);
    logic [15:0] rd;
    int          p;
    enable = en;
    rst    = r;
    rd     = use_gen ? gen_q : rnd_q;
    p      = m_phase();
    if (r) begin
      m_on = 1'b0; m_cnt = 0;
    end else if (!m_on) begin
      if (en) begin m_on = 1'b1; m_t = 0; m_c0 = m_cnt; end
    end else if (!en) begin
      m_cnt = (m_c0 + m_t / P) % 8;
      m_on  = 1'b0;
    end else begin
      if (p == 1) m_lat = rd;
      m_t++;
    end
    @(posedge clk);
    #1;
    cyc_n++;
  endtask

  task automatic test_reset();
    use_gen = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, 1'b1);
      n_chk++;
      if (actual_out() !== {3'd0, 8'hFF, 8'h00, 8'h00, 1'b0}) begin
        n_err++;
        $display("FAIL reset_state cyc %0d: got %h expected %h", cyc_n, actual_out(), {3'd0, 8'hFF, 8'h00, 8'h00, 1'b0});
      end
    end
  endtask

  task automatic test_first_row();
    for (int c = 1; c <= 10; c++) begin
      tick(1'b1, 1'b0);
      n_chk++;
      if (actual_out() !== expect_out()) begin
        n_err++;
        $display("FAIL first_row_model cyc %0d: got %h expected %h", c, actual_out(), expect_out());
      end
      if (c == 1) begin
        n_chk++;
        if (frame_start !== 1'b1 || count !== 3'd0) begin
          n_err++;
          $display("FAIL first_frame_start cyc %0d: got fs=%b count=%0d expected fs=1 count=0", c, frame_start, count);
        end
      end
      if (c >= 3 && c <= 2 + D) begin
        n_chk++;
        if (row_sel !== 8'hFE || col_red !== 8'h81) begin
          n_err++;
          $display("FAIL row0_display cyc %0d: got row_sel=%h col_red=%h expected fe 81", c, row_sel, col_red);
        end
      end
      if (c >= 3 + D && c <= 2 + D + B) begin
        n_chk++;
        if (row_sel !== 8'hFF || col_red !== 8'h00 || col_green !== 8'h00) begin
          n_err++;
          $display("FAIL row0_blank cyc %0d: got row_sel=%h cols=%h/%h expected ff 00/00", c, row_sel, col_red, col_green);
        end
      end
      if (c == 3 + D + B) begin
        n_chk++;
        if (count !== 3'd1) begin
          n_err++;
          $display("FAIL row1_request cyc %0d: got count=%0d expected 1", c, count);
        end
      end
    end
  endtask

  task automatic test_full_frame();
    int fs_a = -1;
    int fs_b = -1;
    for (int i = 0; i < 2 * F + 4; i++) begin
      tick(1'b1, 1'b0);
      n_chk++;
      if (actual_out() !== expect_out()) begin
        n_err++;
        $display("FAIL full_frame_model cyc %0d: got %h expected %h", cyc_n, actual_out(), expect_out());
      end
      if (frame_start === 1'b1) begin
        if (fs_a < 0) fs_a = cyc_n;
        else if (fs_b < 0) fs_b = cyc_n;
      end
    end
    n_chk++;
    if (fs_a < 0 || fs_b - fs_a != F) begin
      n_err++;
      $display("FAIL frame_period: got starts at %0d and %0d expected spacing %0d", fs_a, fs_b, F);
    end
  endtask

  task automatic test_enable_drop();
    for (int i = 0; i < 2 * F && !(m_on && m_row() == 3 && m_phase() >= 2 && m_phase() < 2 + D); i++) begin
      tick(1'b1, 1'b0);
      n_chk++;
      if (actual_out() !== expect_out()) begin
        n_err++;
        $display("FAIL seek_row3 cyc %0d: got %h expected %h", cyc_n, actual_out(), expect_out());
      end
    end
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 1'b0);
      n_chk++;
      if (actual_out() !== {3'd3, 8'hFF, 8'h00, 8'h00, 1'b0}) begin
        n_err++;
        $display("FAIL enable_drop cyc %0d: got %h expected %h", cyc_n, actual_out(), {3'd3, 8'hFF, 8'h00, 8'h00, 1'b0});
      end
    end
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, 1'b0);
      n_chk++;
      if (actual_out() !== expect_out()) begin
        n_err++;
        $display("FAIL reenable_model cyc %0d: got %h expected %h", cyc_n, actual_out(), expect_out());
      end
    end
    n_chk++;
    if (row_sel !== 8'hF7 || count !== 3'd3) begin
      n_err++;
      $display("FAIL reenable_row3: got row_sel=%h count=%0d expected f7 3", row_sel, count);
    end
  endtask

  task automatic test_reset_mid_row();
    for (int i = 0; i < 2 * F && !(m_on && m_row() == 5 && m_phase() >= 2 && m_phase() < 2 + D); i++) begin
      tick(1'b1, 1'b0);
      n_chk++;
      if (actual_out() !== expect_out()) begin
        n_err++;
        $display("FAIL seek_row5 cyc %0d: got %h expected %h", cyc_n, actual_out(), expect_out());
      end
    end
    tick(1'b1, 1'b1);
    n_chk++;
    if (actual_out() !== {3'd0, 8'hFF, 8'h00, 8'h00, 1'b0}) begin
      n_err++;
      $display("FAIL reset_mid_row: got %h expected %h", actual_out(), {3'd0, 8'hFF, 8'h00, 8'h00, 1'b0});
    end
    tick(1'b1, 1'b0);
    n_chk++;
    if (frame_start !== 1'b1 || count !== 3'd0 || row_sel !== 8'hFF) begin
      n_err++;
      $display("FAIL restart_frame_start: got fs=%b count=%0d row_sel=%h expected 1 0 ff", frame_start, count, row_sel);
    end
  endtask

  task automatic test_random_data();
    logic en;
    use_gen = 1'b0;
    for (int i = 0; i < 3 * F; i++) begin
      rnd_q = 16'($urandom);
`ifdef SCAN_BRIGHTNESS_EN
      br_q = 3'($urandom_range(0, 7));
`endif
      en = ($urandom_range(0, 29) != 0);
      tick(en, 1'b0);
      n_chk++;
      if (actual_out() !== expect_out()) begin
        n_err++;
        $display("FAIL random_data_model cyc %0d: got %h expected %h", cyc_n, actual_out(), expect_out());
      end
      n_chk++;
      if ($countones(~row_sel) > 1) begin
        n_err++;
        $display("FAIL row_sel_onehot cyc %0d: got %h expected at most one low bit", cyc_n, row_sel);
      end
    end
    use_gen = 1'b1;
    br_q = 3'd7;
  endtask

`ifdef SCAN_BRIGHTNESS_EN
  task automatic test_brightness();
    logic [2:0] levels[4];
    int         want[4];
    int         lit;
    levels = '{3'd1, 3'd7, 3'd0, 3'd3};
    want   = '{2, 8, 1, 4};
    for (int k = 0; k < 4; k++) begin
      br_q = levels[k];
      lit  = 0;
      tick(1'b1, 1'b0);
      for (int i = 0; i < 2 * P && !(m_on && m_phase() == 2); i++) tick(1'b1, 1'b0);
      for (int i = 0; i < D; i++) begin
        n_chk++;
        if (actual_out() !== expect_out()) begin
          n_err++;
          $display("FAIL brightness_model cyc %0d: got %h expected %h", cyc_n, actual_out(), expect_out());
        end
        if (col_red !== 8'h00) lit++;
        tick(1'b1, 1'b0);
      end
      n_chk++;
      if (lit != want[k]) begin
        n_err++;
        $display("FAIL brightness_%0d: got %0d lit cycles expected %0d", levels[k], lit, want[k]);
      end
    end
    br_q = 3'd7;
  endtask
`endif

  initial begin
    #(200000);
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_first_row();
    test_full_frame();
    test_enable_drop();
    test_reset_mid_row();
    test_random_data();
`ifdef SCAN_BRIGHTNESS_EN
    test_brightness();
`endif
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
